// File: rtl/instruction_block_memory_if.sv
// Instruction-fetch refill bus between the icache controller (master) and the
// block memory (slave): level read request, block address, 128-bit data, busywait.
interface instruction_block_memory_if;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_readdata,
    input  mem_busywait
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_readdata,
    output mem_busywait
  );
endinterface

// File: rtl/instruction_block_memory.sv
// Word-organised instruction store serving 128-bit block refills after a fixed
// latency, with a 32-bit preload port that stays writable in every FSM state.
module instruction_block_memory #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 40,
  parameter int WORD_ADDR_W  = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  instruction_block_memory_if.slave bus,
  input  logic                   load_en_i,
  input  logic [WORD_ADDR_W-1:0] load_addr_i,
  input  logic [31:0]            load_data_i
);

  localparam int ROWS  = DEPTH_WORDS / 4;
  localparam int ROW_W = WORD_ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       count_q, count_d;
  logic [27:0]      addr_q, addr_d;
  logic             busy_q, busy_d;
  logic             complete;
  logic             in_range;
  logic [ROW_W-1:0] row;
  logic [3:0][31:0] words;

  assign in_range = (addr_q < 28'(ROWS));
  assign row      = addr_q[ROW_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.mem_read) begin
          addr_d  = bus.mem_address;
          count_d = 8'(READ_LATENCY - 1);
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.mem_read) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (count_q == 8'd0) begin
          complete = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // One bank per word offset so a whole block is read in a single cycle while
  // preload still writes individual words. Array sampled only on completion.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [31:0] mem [ROWS];
    logic [31:0] word_q;

    always_ff @(posedge clock) begin
      if (load_en_i && (load_addr_i[1:0] == 2'(gi)))
        mem[load_addr_i[WORD_ADDR_W-1:2]] <= load_data_i;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        word_q <= '0;
      else if (complete)
        word_q <= in_range ? mem[row] : 32'd0;
    end

    assign words[gi] = word_q;
  end

  assign bus.mem_readdata = words;
  assign bus.mem_busywait = busy_q;

endmodule

// File: tb/tb_instruction_block_memory.sv
// Directed bench: table of block reads plus hand sequences for abort, reset,
// DONE turnaround, preload races and the single-cycle latency variant.
module tb_instruction_block_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  int total = 0;
  int bad   = 0;

  instruction_block_memory_if bus0 ();
  instruction_block_memory_if bus1 ();

  instruction_block_memory #(.DEPTH_WORDS(1024), .READ_LATENCY(4), .WORD_ADDR_W(10)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  instruction_block_memory #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .WORD_ADDR_W(10)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  always #5 clock = ~clock;

  localparam logic [127:0] BLK0 = 128'h00300193_00200113_00100093_00000013;
  localparam logic [127:0] BLK1 = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] BLKL = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] exp;
    int           exp_cycles;
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 0) ? bus0.mem_busywait : bus1.mem_busywait;
  endfunction

  function automatic logic [127:0] get_data(input int w);
    return (w == 0) ? bus0.mem_readdata : bus1.mem_readdata;
  endfunction

  task automatic set_req(input int w, input logic rd, input logic [27:0] addr);
    if (w == 0) begin
      bus0.mem_read = rd;
      bus0.mem_address = addr;
    end else begin
      bus1.mem_read = rd;
      bus1.mem_address = addr;
    end
  endtask

  task automatic load_word(input logic [9:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Count busy cycles from the accept edge until busywait falls (bounded).
  task automatic count_busy(input int w, inout int cycles);
    while (get_busy(w) && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic do_read(input int w, input logic [27:0] addr,
                         output logic [127:0] data, output int cycles);
    set_req(w, 1'b1, addr);
    tick();
    cycles = 0;
    count_busy(w, cycles);
    data = get_data(w);
    set_req(w, 1'b0, addr);
    tick();
    $display("read dut%0d addr=%0d cycles=%0d data=%h", w, addr, cycles, data);
  endtask

  initial begin
    vec_t         vecs[6];
    logic [127:0] data;
    int           cyc;

    vecs[0] = '{28'd0,         BLK0,   4};
    vecs[1] = '{28'd1,         BLK1,   4};
    vecs[2] = '{28'd255,       BLKL,   4};
    vecs[3] = '{28'd256,       128'd0, 4};
    vecs[4] = '{28'd300,       128'd0, 4};
    vecs[5] = '{28'hFFFFFFF,   128'd0, 4};

    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    #2;
    check_int("reset_busy", int'(bus0.mem_busywait), 0);
    check128("reset_data", bus0.mem_readdata, 128'd0);
    tick();
    reset = 1'b0;

    load_word(10'd0, 32'h00000013);
    load_word(10'd1, 32'h00100093);
    load_word(10'd2, 32'h00200113);
    load_word(10'd3, 32'h00300193);
    load_word(10'd4, 32'h000000A0);
    load_word(10'd5, 32'h000000A1);
    load_word(10'd6, 32'h000000A2);
    load_word(10'd7, 32'h000000A3);
    for (int k = 0; k < 4; k++) load_word(10'(1020 + k), 32'hCAFE0000 + 32'(k));

    for (int i = 0; i < 6; i++) begin
      do_read(0, vecs[i].addr, data, cyc);
      check_int($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
      check128($sformatf("vec%0d_data", i), data, vecs[i].exp);
    end

    // Latency-1 instance
    do_read(1, 28'd0, data, cyc);
    check_int("lat1_cycles", cyc, 1);
    check128("lat1_data", data, BLK0);
    do_read(1, 28'd1, data, cyc);
    check_int("lat1b_cycles", cyc, 1);
    check128("lat1b_data", data, BLK1);

    // Address change during BUSY is ignored
    set_req(0, 1'b1, 28'd1);
    tick();
    set_req(0, 1'b1, 28'd0);
    cyc = 0;
    count_busy(0, cyc);
    $display("read addr-change cycles=%0d data=%h", cyc, bus0.mem_readdata);
    check_int("addrchg_cycles", cyc, 4);
    check128("addrchg_data", bus0.mem_readdata, BLK1);
    set_req(0, 1'b0, 28'd0);
    tick();

    // Abort after two BUSY cycles
    set_req(0, 1'b1, 28'd0);
    tick();
    tick();
    check_int("abort_busy_before", int'(bus0.mem_busywait), 1);
    set_req(0, 1'b0, 28'd0);
    tick();
    $display("abort busy=%0d data=%h", bus0.mem_busywait, bus0.mem_readdata);
    check_int("abort_busy_after", int'(bus0.mem_busywait), 0);
    check128("abort_data_held", bus0.mem_readdata, BLK1);
    tick();
    check_int("abort_idle", int'(bus0.mem_busywait), 0);
    do_read(0, 28'd0, data, cyc);
    check_int("post_abort_cycles", cyc, 4);
    check128("post_abort_data", data, BLK0);

    // DONE lasts one cycle; held mem_read restarts a read afterwards
    set_req(0, 1'b1, 28'd1);
    tick();
    cyc = 0;
    count_busy(0, cyc);
    check_int("done_cycles", cyc, 4);
    check128("done_data", bus0.mem_readdata, BLK1);
    tick();
    check_int("done_turnaround", int'(bus0.mem_busywait), 0);
    tick();
    check_int("done_reaccept", int'(bus0.mem_busywait), 1);
    $display("held read restarted busy=%0d", bus0.mem_busywait);
    set_req(0, 1'b0, 28'd1);
    tick();
    check_int("done_reabort", int'(bus0.mem_busywait), 0);

    // Asynchronous reset on the second BUSY cycle
    set_req(0, 1'b1, 28'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    $display("async reset busy=%0d data=%h", bus0.mem_busywait, bus0.mem_readdata);
    check_int("arst_busy", int'(bus0.mem_busywait), 0);
    check128("arst_data", bus0.mem_readdata, 128'd0);
    set_req(0, 1'b0, 28'd0);
    tick();
    tick();
    reset = 1'b0;
    do_read(0, 28'd0, data, cyc);
    check_int("arst_after_cycles", cyc, 4);
    check128("arst_after_data", data, BLK0);

    // Write in the completion cycle is not seen by that read
    set_req(0, 1'b1, 28'd1);
    tick();
    cyc = 0;
    while (bus0.mem_busywait && cyc < 100) begin
      cyc++;
      if (cyc == 4) begin
        load_en = 1'b1;
        load_addr = 10'd4;
        load_data = 32'h000000B0;
      end
      tick();
    end
    load_en = 1'b0;
    $display("completion-write read cycles=%0d data=%h", cyc, bus0.mem_readdata);
    check_int("cwrite_cycles", cyc, 4);
    check128("cwrite_data", bus0.mem_readdata, BLK1);
    set_req(0, 1'b0, 28'd1);
    tick();
    do_read(0, 28'd1, data, cyc);
    check128("cwrite_visible_next", data, 128'h000000A3_000000A2_000000A1_000000B0);

    // Write during BUSY is seen by that read
    set_req(0, 1'b1, 28'd0);
    tick();
    cyc = 1;
    load_en = 1'b1;
    load_addr = 10'd2;
    load_data = 32'hDEADBEEF;
    tick();
    load_en = 1'b0;
    count_busy(0, cyc);
    $display("busy-write read cycles=%0d data=%h", cyc, bus0.mem_readdata);
    check_int("bwrite_cycles", cyc, 4);
    check128("bwrite_data", bus0.mem_readdata, 128'h00300193_DEADBEEF_00100093_00000013);
    set_req(0, 1'b0, 28'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_block_memory.md
Name: instruction_block_memory

Overview:
- Responder side of the instruction-fetch refill interface: a word-organised instruction store that serves 128-bit block reads.
- Requests come from the instruction cache controller as mem_read plus a 28-bit block address.
- Models multi-cycle main-memory latency with a counter-driven FSM and a mem_busywait handshake.
- Includes a word-wide preload port so the bench and boot logic can load programs without file I/O.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit instruction words stored; must be a multiple of 4.
- READ_LATENCY, 40, clock cycles mem_busywait stays high per accepted read; legal range 1..255.
- WORD_ADDR_W, 10, width of load_addr; equals log2(DEPTH_WORDS).

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- mem_read  in  1  block read request from cache controller; level, held until served.
- mem_address  in  28  block address; byte address bits [31:4].
- mem_readdata  out  128  returned block; [31:0]=word offset 0 … [127:96]=word offset 3.
- mem_busywait  out  1  high while a read is in progress.
- load_en  in  1  preload write strobe.
- load_addr  in  WORD_ADDR_W  preload word index.
- load_data  in  32  preload word.

Behaviour:
- Reset: reset, asynchronous, active-high; clock clock.
  - Reset forces state IDLE, mem_busywait=0, mem_readdata=0, latency counter=0, latched address=0.
  - Storage array is NOT cleared, so preloaded programs survive reset.
- Storage: array of DEPTH_WORDS x 32. Block b maps to words 4b..4b+3; word 4b+k goes to mem_readdata[32k+31:32k].
- Out of range: if 4b >= DEPTH_WORDS, the read completes normally with mem_readdata=0.
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - mem_busywait=0.
  - On posedge with mem_read=1: latch mem_address, load counter with READ_LATENCY-1, set mem_busywait=1, go to BUSY.
- BUSY:
  - mem_address changes are ignored; the latched address is used.
  - If mem_read=0 at a posedge (abort): go to IDLE, mem_busywait=0, mem_readdata unchanged.
  - Else if counter==0: load mem_readdata from the array using the latched address, mem_busywait=0, go to DONE.
  - Else: decrement the counter.
  - Net effect: mem_busywait is high for exactly READ_LATENCY cycles, and data is valid in the same cycle mem_busywait falls.
- DONE:
  - Single turnaround cycle; mem_read is ignored; unconditionally go to IDLE.
  - If the requester keeps mem_read high past DONE, a new read of the current mem_address starts in IDLE.
- Data hold: mem_readdata holds its value from completion until the next completion or reset.
- Preload:
  - On posedge with load_en=1, array[load_addr] <= load_data, in any state.
  - Writes to the block currently in BUSY are visible in that read, because the array is sampled at completion.
  - A write in the completion cycle is not visible to that read.
- Simultaneous load_en and read acceptance in IDLE: both take effect.
- Reset mid-BUSY: the read is abandoned immediately; mem_busywait drops asynchronously.
- READ_LATENCY=1: mem_busywait is high for one cycle; the accept edge loads counter 0 and the next edge completes.

Test Plan:
- Preload words 0..7 with 0x00000013, 0x00100093, 0x00200113, 0x00300193, 0xA0, 0xA1, 0xA2, 0xA3; READ_LATENCY=4; mem_read=1, mem_address=0 -> mem_busywait high for exactly 4 cycles, then mem_readdata=0x00300193_00200113_00100093_00000013 with mem_busywait=0 in that cycle; DONE lasts one cycle.
- Same setup, mem_address=1, with mem_address changed to 0 during BUSY -> returns 0x000000A3_000000A2_000000A1_000000A0, unaffected by the address change.
- Abort: mem_read dropped after 2 BUSY cycles -> mem_busywait=0 on the next edge, mem_readdata keeps its previous value, FSM is IDLE; a fresh read then takes the full 4 cycles.
- Out of range: DEPTH_WORDS=1024, mem_address=300 -> completes after 4 cycles with mem_readdata=0.
- Reset asserted on the second BUSY cycle -> mem_busywait and mem_readdata go to 0 without waiting for a clock edge; after release, a read of block 0 still returns the preloaded data.
- Preload write to word 2 (0xDEADBEEF) during BUSY of block 0 -> the completed block contains 0xDEADBEEF in bits [95:64]. READ_LATENCY=1 variant -> mem_busywait high for exactly 1 cycle.
